router_fsm: RTL

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_fsm.sv | 125 ++++++++++++
 1 files changed

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - packet router control FSM: address decode, FIFO load, full stall, parity check
module router_fsm #(
    parameter logic [1:0] INVALID_ADDR = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] din,
    input  logic       fifo_full,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_addr,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;

    logic din_ok;
    logic din_empty;
    logic addr_empty;
    logic addr_soft;

    // Only ports 0..2 exist; address 3 never routes even if INVALID_ADDR is overridden.
    assign din_ok = pkt_valid && (din != INVALID_ADDR) && (din != 2'd3);

    always_comb begin
        din_empty  = 1'b0;
        addr_empty = 1'b0;
        addr_soft  = 1'b0;
        case (din)
            2'd0:    din_empty = empty_0;
            2'd1:    din_empty = empty_1;
            2'd2:    din_empty = empty_2;
            default: din_empty = 1'b0;
        endcase
        case (addr_q)
            2'd0:    begin addr_empty = empty_0; addr_soft = soft_reset_0; end
            2'd1:    begin addr_empty = empty_1; addr_soft = soft_reset_1; end
            2'd2:    begin addr_empty = empty_2; addr_soft = soft_reset_2; end
            default: begin addr_empty = 1'b0;    addr_soft = 1'b0;         end
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q == DECODE_ADDRESS && pkt_valid && din != INVALID_ADDR) begin
            addr_d = din;
        end
        // A timeout on the selected port abandons the packet from any active state.
        if (state_q != DECODE_ADDRESS && addr_soft) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (din_ok) state_d = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (addr_empty) state_d = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) state_d = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_d = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = LOAD_PARITY;
                    else                    state_d = LOAD_DATA;
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign detect_addr   = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                        || (state_q == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule
